// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART frame parser.
// Holds the parser state enum, sync byte and timing defaults.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        PAYLOAD,
        CSUM,
        DONE
    } state_e;

    localparam logic [7:0] SYNC_BYTE_DEF    = 8'hA5;
    localparam int         MAX_LEN_DEF      = 16;
    localparam int         CLKS_PER_BIT     = 87;
    localparam int         TIMEOUT_CLKS_DEF = 20 * CLKS_PER_BIT;

endpackage

// File: rtl/uart_frame_parser_if.sv
// Host/receiver bundle of the frame parser.
// master: receiver+host side; slave: the parser.
interface uart_frame_parser_if #(
    parameter int MAX_LEN = 16
);
    localparam int AW = $clog2(MAX_LEN);

    logic          i_Rx_DV;
    logic [7:0]    i_Rx_Byte;
    logic          i_Ack;
    logic [AW-1:0] i_Rd_Addr;
    logic [7:0]    o_Rd_Data;
    logic          o_Frame_Valid;
    logic [7:0]    o_Frame_Len;
    logic          o_Busy;
    logic          o_Crc_Err;
    logic          o_Len_Err;
    logic          o_Timeout_Err;
    logic          o_Ovf_Err;

    modport master (
        output i_Rx_DV, i_Rx_Byte, i_Ack, i_Rd_Addr,
        input  o_Rd_Data, o_Frame_Valid, o_Frame_Len, o_Busy,
        input  o_Crc_Err, o_Len_Err, o_Timeout_Err, o_Ovf_Err
    );

    modport slave (
        input  i_Rx_DV, i_Rx_Byte, i_Ack, i_Rd_Addr,
        output o_Rd_Data, o_Frame_Valid, o_Frame_Len, o_Busy,
        output o_Crc_Err, o_Len_Err, o_Timeout_Err, o_Ovf_Err
    );

endinterface

// File: rtl/uart_frame_buf.sv
// Payload buffer: DEPTH x 8 simple dual-port RAM.
// Ports: sync write (we_i/waddr_i/wdata_i), registered read (raddr_i -> rdata_o).
module uart_frame_buf #(
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [7:0]    wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [7:0]    rdata_o
);

    logic [7:0] mem_q [DEPTH];
    logic [7:0] rdata_q;

    // Storage is never reset; only the read register is.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/uart_frame_parser.sv
// Sync-hunting, length-prefixed frame deframer behind a UART receiver.
// Ports: clk, rst (sync, active-high), bus (slave: rx strobe, host ack/read, status).
module uart_frame_parser
    import uart_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE    = SYNC_BYTE_DEF,
    parameter int         MAX_LEN      = MAX_LEN_DEF,
    parameter int         TIMEOUT_CLKS = TIMEOUT_CLKS_DEF
) (
    input  logic               clk,
    input  logic               rst,
    uart_frame_parser_if.slave bus
);

    localparam int AW = $clog2(MAX_LEN);
    localparam int GW = $clog2(TIMEOUT_CLKS);
    // gap_q counts idle cycles already elapsed; the idle cycle that would
    // bring it to TIMEOUT_CLKS-1 is the expiry cycle.
    localparam logic [GW-1:0] GAP_EXP = GW'(TIMEOUT_CLKS - 2);
    localparam logic [GW-1:0] GAP_MAX = '1;

    state_e        state_q, state_d;
    logic [7:0]    len_q, len_d;
    logic [7:0]    idx_q, idx_d;
    logic [7:0]    sum_q, sum_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [7:0]    flen_q, flen_d;
    logic          valid_q, valid_d;
    logic          crc_q, crc_d;
    logic          lerr_q, lerr_d;
    logic          to_q, to_d;
    logic          ovf_q, ovf_d;
    logic          busy_q;
    logic          we;

    logic       dv;
    logic [7:0] rx;
    logic       timed;
    logic       expire;

    assign dv     = bus.i_Rx_DV;
    assign rx     = bus.i_Rx_Byte;
    assign timed  = (state_q == LEN) || (state_q == PAYLOAD) ||
                    (state_q == CSUM);
    // A byte in the expiry cycle wins over the timeout.
    assign expire = timed && !dv && (gap_q == GAP_EXP);

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx_q;
        sum_d   = sum_q;
        flen_d  = flen_q;
        valid_d = 1'b0;
        crc_d   = 1'b0;
        lerr_d  = 1'b0;
        to_d    = 1'b0;
        ovf_d   = 1'b0;
        we      = 1'b0;

        if (dv || !timed) begin
            gap_d = '0;
        end else if (gap_q != GAP_MAX) begin
            gap_d = gap_q + 1'b1;
        end else begin
            gap_d = gap_q;
        end

        if (expire) begin
            to_d    = 1'b1;
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (dv && rx == SYNC_BYTE) begin
                        state_d = LEN;
                    end
                end
                LEN: begin
                    if (dv) begin
                        if (rx == 8'd0 || rx > 8'(MAX_LEN)) begin
                            lerr_d  = 1'b1;
                            state_d = IDLE;
                        end else begin
                            len_d   = rx;
                            sum_d   = rx;
                            idx_d   = '0;
                            state_d = PAYLOAD;
                        end
                    end
                end
                PAYLOAD: begin
                    if (dv) begin
                        we    = 1'b1;
                        sum_d = sum_q + rx;
                        idx_d = idx_q + 8'd1;
                        if (idx_q + 8'd1 == len_q) begin
                            state_d = CSUM;
                        end
                    end
                end
                CSUM: begin
                    if (dv) begin
                        if (rx == sum_q) begin
                            valid_d = 1'b1;
                            flen_d  = len_q;
                            state_d = DONE;
                        end else begin
                            crc_d   = 1'b1;
                            state_d = IDLE;
                        end
                    end
                end
                DONE: begin
                    // Ack releases the frame and the same-cycle byte is
                    // judged as if already in IDLE.
                    if (bus.i_Ack) begin
                        flen_d  = '0;
                        state_d = (dv && rx == SYNC_BYTE) ? LEN : IDLE;
                    end else if (dv) begin
                        ovf_d = 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            len_q   <= '0;
            idx_q   <= '0;
            sum_q   <= '0;
            gap_q   <= '0;
            flen_q  <= '0;
            valid_q <= 1'b0;
            crc_q   <= 1'b0;
            lerr_q  <= 1'b0;
            to_q    <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            sum_q   <= sum_d;
            gap_q   <= gap_d;
            flen_q  <= flen_d;
            valid_q <= valid_d;
            crc_q   <= crc_d;
            lerr_q  <= lerr_d;
            to_q    <= to_d;
            ovf_q   <= ovf_d;
            busy_q  <= (state_d != IDLE);
        end
    end

    uart_frame_buf #(
        .DEPTH(MAX_LEN)
    ) u_buf (
        .clk    (clk),
        .rst    (rst),
        .we_i   (we),
        .waddr_i(idx_q[AW-1:0]),
        .wdata_i(rx),
        .raddr_i(bus.i_Rd_Addr),
        .rdata_o(bus.o_Rd_Data)
    );

    assign bus.o_Frame_Valid = valid_q;
    assign bus.o_Frame_Len   = flen_q;
    assign bus.o_Busy        = busy_q;
    assign bus.o_Crc_Err     = crc_q;
    assign bus.o_Len_Err     = lerr_q;
    assign bus.o_Timeout_Err = to_q;
    assign bus.o_Ovf_Err     = ovf_q;

endmodule

// File: tb/tb_uart_frame_parser.sv
// Bench for uart_frame_parser: directed steps plus randomized frames.
// Expected results come from frames built and summed in the bench.
module tb_uart_frame_parser;

    localparam int TO = 1740;
    localparam logic [7:0] SY = 8'hA5;

    typedef logic [7:0] bq_t [$];

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    uart_frame_parser_if #(.MAX_LEN(16)) bus();

    uart_frame_parser #(
        .SYNC_BYTE   (SY),
        .MAX_LEN     (16),
        .TIMEOUT_CLKS(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_tot  = 0;
    int n_pass = 0;
    int c_val, c_crc, c_len, c_to, c_ovf, c_multi;
    int last_len;

    task automatic chk(input string tag, input int got, input int exp);
        n_tot++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: got %0d, want %0d", tag, got, exp);
    endtask

    task automatic clr();
        c_val = 0;
        c_crc = 0;
        c_len = 0;
        c_to  = 0;
        c_ovf = 0;
    endtask

    // One clock; outputs sampled 1 time unit after the edge.
    task automatic step();
        int ne;
        @(posedge clk);
        #1;
        ne = 0;
        if (bus.o_Frame_Valid) begin
            c_val++;
            last_len = int'(bus.o_Frame_Len);
        end
        if (bus.o_Crc_Err) begin
            c_crc++;
            ne++;
        end
        if (bus.o_Len_Err) begin
            c_len++;
            ne++;
        end
        if (bus.o_Timeout_Err) begin
            c_to++;
            ne++;
        end
        if (bus.o_Ovf_Err) begin
            c_ovf++;
            ne++;
        end
        if (ne > 1) c_multi++;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic send(input logic [7:0] b);
        bus.i_Rx_DV   = 1'b1;
        bus.i_Rx_Byte = b;
        step();
        bus.i_Rx_DV   = 1'b0;
    endtask

    task automatic ack();
        bus.i_Ack = 1'b1;
        step();
        bus.i_Ack = 1'b0;
    endtask

    function automatic logic [7:0] csum(input bq_t pl);
        int s;
        s = pl.size();
        foreach (pl[i]) s += int'(pl[i]);
        return 8'(s % 256);
    endfunction

    task automatic send_frame(input bq_t pl, input logic [7:0] delta,
                              input int maxgap);
        send(SY);
        idle($urandom_range(0, maxgap));
        send(8'(pl.size()));
        foreach (pl[i]) begin
            idle($urandom_range(0, maxgap));
            send(pl[i]);
        end
        idle($urandom_range(0, maxgap));
        send(csum(pl) + delta);
    endtask

    task automatic rd_check(input string tag, input bq_t pl);
        foreach (pl[i]) begin
            bus.i_Rd_Addr = 4'(i);
            step();
            chk(tag, int'(bus.o_Rd_Data), int'(pl[i]));
        end
    endtask

    initial begin
        bq_t pl;
        bq_t pl2;
        logic [7:0] nb;
        int n;
        bit bad;

        rst           = 1'b1;
        bus.i_Rx_DV   = 1'b0;
        bus.i_Rx_Byte = '0;
        bus.i_Ack     = 1'b0;
        bus.i_Rd_Addr = '0;
        c_multi       = 0;
        last_len      = -1;
        clr();
        idle(2);
        rst = 1'b0;
        chk("rst_busy", int'(bus.o_Busy), 0);
        chk("rst_len", int'(bus.o_Frame_Len), 0);
        chk("rst_rd", int'(bus.o_Rd_Data), 0);
        chk("rst_valid", int'(bus.o_Frame_Valid), 0);

        // Good frame
        clr();
        pl = '{8'h11, 8'h22, 8'h33};
        chk("good_csum_val", int'(csum(pl)), 'h69);
        send_frame(pl, 8'h00, 0);
        chk("good_valid_now", int'(bus.o_Frame_Valid), 1);
        chk("good_len", int'(bus.o_Frame_Len), 3);
        chk("good_busy", int'(bus.o_Busy), 1);
        rd_check("good_rd", pl);
        idle(3);
        chk("good_one_pulse", c_val, 1);
        chk("good_busy_held", int'(bus.o_Busy), 1);
        ack();
        chk("ack_len0", int'(bus.o_Frame_Len), 0);
        chk("ack_busy0", int'(bus.o_Busy), 0);

        // Bad checksum, then recovery
        clr();
        send_frame(pl, 8'hFF, 0);
        chk("crc_err", c_crc, 1);
        chk("crc_novalid", c_val, 0);
        chk("crc_idle", int'(bus.o_Busy), 0);
        pl = '{8'h44};
        send_frame(pl, 8'h00, 0);
        chk("crc_next_valid", c_val, 1);
        chk("crc_next_len", last_len, 1);
        ack();

        // Length limits
        clr();
        send(SY);
        send(8'h00);
        chk("len0_err", c_len, 1);
        send(SY);
        send(8'h11);
        chk("len17_err", c_len, 2);
        chk("len_idle", int'(bus.o_Busy), 0);
        pl = {};
        for (int i = 0; i < 16; i++) pl.push_back(8'(i * 37 + 5));
        send_frame(pl, 8'h00, 0);
        chk("len16_valid", c_val, 1);
        chk("len16_len", int'(bus.o_Frame_Len), 16);
        rd_check("len16_rd", pl);
        ack();

        // Timeout after TO-1 idle edges
        clr();
        send(SY);
        send(8'h03);
        send(8'h11);
        idle(TO - 2);
        chk("to_early", c_to, 0);
        chk("to_busy", int'(bus.o_Busy), 1);
        step();
        chk("to_pulse", int'(bus.o_Timeout_Err), 1);
        chk("to_count", c_to, 1);
        chk("to_idle", int'(bus.o_Busy), 0);

        // Byte in the expiry cycle wins
        clr();
        send(SY);
        send(8'h03);
        send(8'h11);
        idle(TO - 2);
        send(8'h22);
        chk("exp_no_to", c_to, 0);
        chk("exp_busy", int'(bus.o_Busy), 1);
        send(8'h33);
        send(8'h69);
        chk("exp_valid", c_val, 1);
        ack();

        // Noise hunt, payload containing sync byte
        clr();
        send(8'h00);
        send(8'hFF);
        send(8'h5A);
        pl = '{SY, SY};
        send_frame(pl, 8'h00, 0);
        chk("hunt_valid", c_val, 1);
        chk("hunt_len", last_len, 2);
        rd_check("hunt_rd", pl);

        // Second frame without ack overflows byte by byte
        pl2 = '{8'h01, 8'h02};
        send_frame(pl2, 8'h00, 0);
        chk("ovf_count", c_ovf, 5);
        chk("ovf_len_held", int'(bus.o_Frame_Len), 2);
        chk("ovf_busy", int'(bus.o_Busy), 1);
        chk("ovf_novalid", c_val, 1);
        rd_check("ovf_rd", pl);

        // Ack coincident with sync byte
        clr();
        bus.i_Ack = 1'b1;
        send(SY);
        bus.i_Ack = 1'b0;
        chk("ackS_len0", int'(bus.o_Frame_Len), 0);
        chk("ackS_busy", int'(bus.o_Busy), 1);
        chk("ackS_noovf", c_ovf, 0);
        send(8'h01);
        send(8'h07);
        send(8'h08);
        chk("ackS_valid", c_val, 1);
        chk("ackS_flen", last_len, 1);
        pl = '{8'h07};
        rd_check("ackS_rd", pl);
        ack();

        // Reset in mid-payload
        clr();
        send(SY);
        send(8'h04);
        send(8'h01);
        send(8'h02);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mrst_busy", int'(bus.o_Busy), 0);
        chk("mrst_len", int'(bus.o_Frame_Len), 0);
        chk("mrst_rd", int'(bus.o_Rd_Data), 0);
        pl = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        send_frame(pl, 8'h00, 0);
        chk("mrst_valid", c_val, 1);
        chk("mrst_flen", last_len, 4);
        rd_check("mrst_rd", pl);
        ack();

        // Randomized frames with noise and inter-byte gaps
        for (int k = 0; k < 24; k++) begin
            clr();
            n = $urandom_range(0, 3);
            repeat (n) begin
                nb = 8'($urandom);
                if (nb == SY) nb = 8'h00;
                send(nb);
            end
            pl = {};
            n = $urandom_range(1, 16);
            repeat (n) pl.push_back(8'($urandom));
            bad = ($urandom_range(0, 2) == 0);
            nb = bad ? 8'($urandom_range(1, 255)) : 8'h00;
            send_frame(pl, nb, 3);
            if (bad) begin
                chk("rnd_crc", c_crc, 1);
                chk("rnd_crc_nov", c_val, 0);
                chk("rnd_crc_idle", int'(bus.o_Busy), 0);
            end else begin
                chk("rnd_valid", c_val, 1);
                chk("rnd_len", int'(bus.o_Frame_Len), pl.size());
                rd_check("rnd_rd", pl);
                ack();
                chk("rnd_ack", int'(bus.o_Frame_Len), 0);
            end
        end

        chk("err_exclusive", c_multi, 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
